// File: rtl/ft_tx_scheduler.sv
// rtl/ft_tx_scheduler.sv - FT upstream frame scheduler for telemetry packets and link-status reports
//
// Purpose: arbitrates the FT write port between a one-entry telemetry holding register and a
// status-report request flag. Each grant emits one non-interleaved frame of 16-bit words:
// header {HDR_MAGIC, type, seq} followed by the body (and a CRC trailer when enabled).
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   pkt_data, pkt_valid   88-bit telemetry packet and single-cycle strobe (no backpressure)
//   stat_total,
//   stat_mismatch         link counters, snapshotted when a status frame is granted
//   stat_req              pulse requesting a status frame
//   ui_din, ui_din_be,
//   ui_din_valid          FT write word, byte enables and valid
//   ui_din_full           FT TX FIFO full; a word moves when valid && !full
//   busy                  frame in progress (grant through final word transfer)
//   drop_cnt              saturating count of telemetry packets lost to a full holding register
//
// Build option: define FT_TX_SCHED_CRC_EN to append a CRC-16/CCITT trailer word to every frame.

module ft_tx_scheduler #(
  parameter logic [31:0] STAT_PERIOD = 32'd128_000_000,
  parameter logic [3:0]  HDR_MAGIC   = 4'hA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [87:0] pkt_data,
  input  logic        pkt_valid,
  input  logic [31:0] stat_total,
  input  logic [31:0] stat_mismatch,
  input  logic        stat_req,
  output logic [15:0] ui_din,
  output logic [1:0]  ui_din_be,
  output logic        ui_din_valid,
  input  logic        ui_din_full,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  localparam logic GRANT_TELE = 1'b0;
  localparam logic GRANT_STAT = 1'b1;

`ifdef FT_TX_SCHED_CRC_EN
  localparam logic [2:0] TRAILER_WORDS = 3'd1;
`else
  localparam logic [2:0] TRAILER_WORDS = 3'd0;
`endif

  state_t      state;
  logic        hold_valid;
  logic [87:0] hold_data;
  logic        stat_pending;
  logic [31:0] timer;
  logic        last_grant;
  logic        cur_is_stat;
  logic [95:0] frame;       // body words still to send, lowest word first
  logic [2:0]  idx;         // index of the body/trailer word currently presented
  logic [7:0]  seq;

  logic        xfer;
  logic        timer_hit;
  logic        grant_tele;
  logic        grant_stat;
  logic [2:0]  n_body;
  logic [2:0]  last_idx;

  assign xfer      = ui_din_valid && !ui_din_full;
  assign timer_hit = (STAT_PERIOD != 32'd0) && (timer == STAT_PERIOD - 32'd1);

  // On a tie the source that did not win last time goes first.
  assign grant_tele = (state == IDLE) && hold_valid &&
                      (!stat_pending || last_grant == GRANT_STAT);
  assign grant_stat = (state == IDLE) && stat_pending &&
                      (!hold_valid || last_grant == GRANT_TELE);

  assign n_body   = cur_is_stat ? 3'd4 : 3'd6;
  assign last_idx = n_body - 3'd1 + TRAILER_WORDS;

`ifdef FT_TX_SCHED_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_next;

  function automatic logic [15:0] crc16_word(input logic [15:0] c_in, input logic [15:0] w);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ w[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Running CRC including the word on the port right now.
  assign crc_next = crc16_word(crc, ui_din);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      stat_pending <= 1'b0;
      timer        <= '0;
      last_grant   <= GRANT_STAT;
      cur_is_stat  <= 1'b0;
      frame        <= '0;
      idx          <= '0;
      seq          <= '0;
      ui_din       <= '0;
      ui_din_be    <= '0;
      ui_din_valid <= 1'b0;
      busy         <= 1'b0;
      drop_cnt     <= '0;
`ifdef FT_TX_SCHED_CRC_EN
      crc          <= 16'hFFFF;
`endif
    end else begin
      if (STAT_PERIOD != 32'd0)
        timer <= timer_hit ? 32'd0 : timer + 32'd1;

      // A new request in the grant cycle keeps the flag set.
      if (stat_req || timer_hit)
        stat_pending <= 1'b1;
      else if (grant_stat)
        stat_pending <= 1'b0;

      if (pkt_valid && (!hold_valid || grant_tele)) begin
        hold_valid <= 1'b1;
        hold_data  <= pkt_data;
      end else if (pkt_valid) begin
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end else if (grant_tele) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grant_tele || grant_stat) begin
            state        <= HDR;
            busy         <= 1'b1;
            ui_din_valid <= 1'b1;
            ui_din_be    <= 2'b11;
            ui_din       <= {HDR_MAGIC, (grant_stat ? 4'h2 : 4'h1), seq};
            cur_is_stat  <= grant_stat;
            last_grant   <= grant_stat ? GRANT_STAT : GRANT_TELE;
            frame        <= grant_stat ? {32'h0, stat_mismatch, stat_total}
                                       : {8'h00, hold_data};
`ifdef FT_TX_SCHED_CRC_EN
            crc          <= 16'hFFFF;
`endif
          end
        end
        HDR: begin
          if (xfer) begin
            state     <= BODY;
            idx       <= 3'd0;
            ui_din    <= frame[15:0];
            ui_din_be <= 2'b11;
            frame     <= {16'h0, frame[95:16]};
`ifdef FT_TX_SCHED_CRC_EN
            crc       <= crc_next;
`endif
          end
        end
        BODY: begin
          if (xfer) begin
            if (idx == last_idx) begin
              state        <= IDLE;
              busy         <= 1'b0;
              ui_din_valid <= 1'b0;
              ui_din       <= '0;
              ui_din_be    <= '0;
              seq          <= seq + 8'd1;
            end else begin
              idx <= idx + 3'd1;
`ifdef FT_TX_SCHED_CRC_EN
              crc <= crc_next;
              if ((idx + 3'd1) == n_body) begin
                ui_din    <= crc_next;
                ui_din_be <= 2'b11;
              end else
`endif
              begin
                ui_din    <= frame[15:0];
                frame     <= {16'h0, frame[95:16]};
                // Final telemetry word carries only the top data byte.
                ui_din_be <= (!cur_is_stat && idx == 3'd4) ? 2'b01 : 2'b11;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
